// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the parallel-to-serial transmitter:
//     - tx_state_t : FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3)
//     - clamp_len  : maps an out-of-range data length onto the full word width
//     - even_parity: XOR of the low 'len' bits of a word
//   No ports; imported by the transmitter and its holding register.
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } tx_state_t;

    // Widest word even_parity can handle; callers zero-extend into this.
    localparam int unsigned PARITY_MAX_W = 64;

    // A length of zero, or one longer than the word, means "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    // Even parity: the returned bit makes the total count of ones (data bits
    // plus parity bit) even. Only bits [len-1:0] take part.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word,
                                         input int unsigned             len);
        logic [PARITY_MAX_W-1:0] mask;
        if (len >= PARITY_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << len) - 64'd1;
        end
        return ^(word & mask);
    endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// ---------------------------------------------------------------------------
// serial_hold_reg
//   One-entry holding register with a valid/ready input side and a
//   full/pop output side.
//
//   Handshake: a word is taken on a rising edge where in_valid && in_ready.
//   in_ready is simply !full, so it is a registered signal. The consumer
//   removes the entry by asserting out_pop while out_valid is high.
//
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset
//     in_valid    producer offers in_data
//     in_ready    register is empty and can take a word
//     in_data     payload to store
//     out_valid   register holds a word
//     out_data    stored payload
//     out_pop     consumer takes the stored word this edge
//     full_next   value out_valid will have after the coming edge
// ---------------------------------------------------------------------------
module serial_hold_reg
    import serial_pkg::*;
#(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_pop,
    output logic         full_next
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         push;

    // A push is only possible while empty, so push and pop never meet on a
    // full register; if they ever did the new word would win.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        push   = in_valid && !full_q;
        if (out_pop) begin
            full_d = 1'b0;
            data_d = '0;
        end
        if (push) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;
    assign full_next = full_d;

endmodule

// File: rtl/parallel_serial_tx.sv
// ---------------------------------------------------------------------------
// parallel_serial_tx
//   Parallel-to-serial transmitter. Words arrive over a valid/ready
//   handshake; each is sent as a frame of one start bit (0), 1..DATA_WIDTH
//   data bits (LSB- or MSB-first) and an optional even-parity bit. One word
//   can wait in a holding register while another shifts, so frames follow
//   each other with no idle cycle. The line is high-Z when nothing is sent.
//
//   Handshake: din is accepted on a rising edge where din_valid && din_ready.
//   din_ready equals !hold_full. bit_lngt, msb_first and parity_en are
//   captured together with din and ignored at any other time.
//
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset
//     din_valid   word on din offered
//     din_ready   block can accept a word
//     din         parallel word
//     bit_lngt    data bits to send (0 or > DATA_WIDTH means DATA_WIDTH)
//     msb_first   1: bit bit_lngt-1 first, 0: bit 0 first
//     parity_en   append even-parity bit
//     dout        serial line, 1'bz when idle
//     dout_en     dout is being driven
//     busy        frame in progress or word pending
//     tx_done     high during the last bit of each frame
//
//   DATA_WIDTH must not exceed 64 and 2**LEN_WIDTH must exceed DATA_WIDTH.
// ---------------------------------------------------------------------------
module parallel_serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LEN_WIDTH-1:0]  bit_lngt,
    input  logic                  msb_first,
    input  logic                  parity_en,
    output logic                  dout,
    output logic                  dout_en,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned PAY_W = DATA_WIDTH + LEN_WIDTH + 2;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef struct packed {
        logic                  par;
        logic                  msb;
        logic [LEN_WIDTH-1:0]  len;
        logic [DATA_WIDTH-1:0] word;
    } frame_cfg_t;

    // FSM and active-frame state
    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  cnt_d;
    frame_cfg_t            act_q;
    frame_cfg_t            act_d;
    logic                  act_valid_q;
    logic                  act_valid_d;

    // Registered outputs
    logic                  dout_bit_q;
    logic                  dout_bit_d;
    logic                  dout_en_q;
    logic                  dout_en_d;
    logic                  tx_done_q;
    logic                  tx_done_d;
    logic                  busy_q;
    logic                  busy_d;

    // Holding register interface
    frame_cfg_t            din_cfg;
    frame_cfg_t            hold_cfg;
    logic                  hold_ready;
    logic                  hold_full;
    logic                  hold_full_next;
    logic                  hold_pop;
    logic                  hold_in_valid;

    logic                  accept;
    logic                  direct_load;
    logic                  eof;
    logic [LEN_WIDTH-1:0]  bit_idx;
    logic [DATA_WIDTH-1:0] data_shift;

    // Lengths are clamped once at capture, so everything downstream can
    // trust act.len to be in 1..DATA_WIDTH.
    always_comb begin
        din_cfg.word = din;
        din_cfg.len  = LEN_WIDTH'(clamp_len(32'(bit_lngt), DATA_WIDTH));
        din_cfg.msb  = msb_first;
        din_cfg.par  = parity_en;
    end

    assign accept        = din_valid && hold_ready;
    // A word that goes straight into the active register must not also be
    // pushed into the holding register.
    assign hold_in_valid = din_valid && !direct_load;

    serial_hold_reg #(
        .W (PAY_W)
    ) u_hold (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (hold_in_valid),
        .in_ready  (hold_ready),
        .in_data   (din_cfg),
        .out_valid (hold_full),
        .out_data  (hold_cfg),
        .out_pop   (hold_pop),
        .full_next (hold_full_next)
    );

    // Next-state logic. The state names the bit being driven during the
    // cycle; the output flops are loaded from the next-state values so the
    // line changes on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        direct_load = 1'b0;
        hold_pop    = 1'b0;
        eof         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A word loaded on the previous edge starts its frame now;
                // anything arriving meanwhile goes to the holding register.
                if (act_valid_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else if (accept) begin
                    act_d       = din_cfg;
                    act_valid_d = 1'b1;
                    direct_load = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == act_q.len - LEN_ONE) begin
                    if (act_q.par) begin
                        state_d = ST_PARITY;
                    end else begin
                        eof = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + LEN_ONE;
                end
            end
            ST_PARITY: begin
                eof = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of frame: chain the next word straight into a start bit if
        // one is pending or arriving right now, otherwise go idle.
        if (eof) begin
            cnt_d = '0;
            if (hold_full) begin
                act_d    = hold_cfg;
                hold_pop = 1'b1;
                state_d  = ST_START;
            end else if (accept) begin
                act_d       = din_cfg;
                direct_load = 1'b1;
                state_d     = ST_START;
            end else begin
                act_d       = '0;
                act_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        end
    end

    // Output decode from the next-state values.
    always_comb begin
        bit_idx    = act_d.msb ? (act_d.len - LEN_ONE - cnt_d) : cnt_d;
        data_shift = act_d.word >> bit_idx;
        dout_en_d  = (state_d != ST_IDLE);

        case (state_d)
            ST_DATA:   dout_bit_d = data_shift[0];
            ST_PARITY: dout_bit_d = even_parity(64'(act_d.word), 32'(act_d.len));
            default:   dout_bit_d = 1'b0;
        endcase

        tx_done_d = ((state_d == ST_DATA) && (cnt_d == act_d.len - LEN_ONE) && !act_d.par)
                 || (state_d == ST_PARITY);

        // A loaded word waiting for its start bit already counts as a frame
        // in progress (state is never non-IDLE without an active word).
        busy_d = act_valid_d || (state_d != ST_IDLE) || hold_full_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            dout_bit_q  <= 1'b0;
            dout_en_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            dout_bit_q  <= dout_bit_d;
            dout_en_q   <= dout_en_d;
            tx_done_q   <= tx_done_d;
            busy_q      <= busy_d;
        end
    end

    assign dout      = dout_en_q ? dout_bit_q : 1'bz;
    assign dout_en   = dout_en_q;
    assign busy      = busy_q;
    assign tx_done   = tx_done_q;
    assign din_ready = hold_ready;

endmodule

// File: tb/tb_parallel_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_parallel_serial_tx
//   Bench for parallel_serial_tx. Each accepted word is expanded into its
//   expected frame (start, data bits, parity) and queued; a monitor on the
//   falling edge pops one entry per driven cycle and checks line and tx_done,
//   and checks the line is high-Z whenever it is not driven.
// ---------------------------------------------------------------------------
module tb_parallel_serial_tx;

    localparam int DW = 14;
    localparam int LW = 4;

    logic          clk;
    logic          rstn;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din;
    logic [LW-1:0] bit_lngt;
    logic          msb_first;
    logic          parity_en;
    wire           dout;
    logic          dout_en;
    logic          busy;
    logic          tx_done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected line entries: {bit, last_bit_of_frame}
    logic [1:0] exp_q[$];

    parallel_serial_tx #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .bit_lngt  (bit_lngt),
        .msb_first (msb_first),
        .parity_en (parity_en),
        .dout      (dout),
        .dout_en   (dout_en),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame = start 0, then L data bits in the requested order, then the
    // even-parity bit if enabled.
    task automatic push_frame(input logic [DW-1:0] w, input int bl, input logic msb, input logic par);
        int   len;
        int   idx;
        int   wi;
        logic b;
        logic last;
        wi  = int'(w);
        len = (bl == 0 || bl > DW) ? DW : bl;
        exp_q.push_back(2'b00);
        for (int k = 0; k < len; k++) begin
            idx  = msb ? (len - 1 - k) : k;
            b    = 1'((wi >> idx) & 1);
            last = (k == len - 1) && !par;
            exp_q.push_back({b, last});
        end
        if (par) begin
            b = 1'($countones(wi & ((1 << len) - 1)) & 1);
            exp_q.push_back({b, 1'b1});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        if (dout_en) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_drive", 32'(dout_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("dout", 32'(dout), 32'(e[1]));
                check_eq("tx_done", 32'(tx_done), 32'(e[0]));
            end
        end else begin
            check_eq("idle_z", 32'(dout === 1'bz), 32'd1);
            check_eq("idle_tx_done", 32'(tx_done), 32'd0);
        end
    end

    // ---------------- drivers ----------------
    // Offers a word and returns just after the accepting rising edge.
    task automatic send(input logic [DW-1:0] w, input int bl, input logic msb, input logic par);
        int n;
        @(negedge clk);
        din       = w;
        bit_lngt  = LW'(bl);
        msb_first = msb;
        parity_en = par;
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            din_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(w, bl, msb, par);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_en) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check_eq("drain_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int run;
        int dones;
        int n;

        rstn      = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        bit_lngt  = '0;
        msb_first = 1'b0;
        parity_en = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_dout_en", 32'(dout_en), 32'd0);
        check_eq("rst_din_ready", 32'(din_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_tx_done", 32'(tx_done), 32'd0);
        check_eq("rst_z", 32'(dout === 1'bz), 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, LSB-first, no parity; start bit one edge after accept.
        send(14'h2A5, 8, 1'b0, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("lat_idle", 32'(dout_en), 32'd0);
        @(negedge clk);
        check_eq("lat_start_en", 32'(dout_en), 32'd1);
        check_eq("lat_start_bit", 32'(dout), 32'd0);
        check_eq("busy_frame", 32'(busy), 32'd1);
        drain();

        // Same word, MSB-first with parity.
        send(14'h2A5, 8, 1'b1, 1'b1);
        drop_valid();
        drain();

        // Back-to-back: three 4-bit words with valid held high.
        fork
            begin
                send(14'h00F, 4, 1'b0, 1'b0);
                send(14'h000, 4, 1'b0, 1'b0);
                #1;
                check_eq("ready_drop", 32'(din_ready), 32'd0);
                send(14'h009, 4, 1'b0, 1'b0);
                drop_valid();
            end
            begin
                n = 0;
                while (!dout_en && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                run   = 0;
                dones = 0;
                while (dout_en && run < 100) begin
                    run++;
                    if (tx_done) dones++;
                    @(negedge clk);
                end
                check_eq("b2b_run", 32'(run), 32'd15);
                check_eq("b2b_done", 32'(dones), 32'd3);
            end
        join
        drain();

        // Length clamp.
        send(14'h3FFF, 0, 1'b0, 1'b0);
        drop_valid();
        drain();
        send(14'h3FFF, 15, 1'b0, 1'b0);
        drop_valid();
        drain();
        send(14'h2C35, 0, 1'b1, 1'b1);
        drop_valid();
        drain();

        // Reset during data bit 3 with a second word pending.
        send(14'h1234, 14, 1'b0, 1'b0);
        send(14'h0ABC, 6, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        din_valid = 1'b0;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        check_eq("pre_rst_en", 32'(dout_en), 32'd1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check_eq("mid_rst_z", 32'(dout === 1'bz), 32'd1);
        check_eq("mid_rst_en", 32'(dout_en), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(din_ready), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // Configuration changes mid-frame must not affect the current frame.
        send(14'h1B6D, 10, 1'b0, 1'b1);
        drop_valid();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            msb_first = ~msb_first;
            bit_lngt  = LW'($urandom_range(0, 15));
            parity_en = ~parity_en;
        end
        drain();

        // Randomized traffic with random gaps between offers.
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drop_valid();
                repeat (gap - 1) @(negedge clk);
            end
            send(DW'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        drop_valid();
        drain();

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
